// File: rtl/uiudp_rx_mp.sv
// uiudp_rx_mp: UDP receive parser, strips the 8-byte header and forwards payload.
// Define UIUDP_RX_PORT_FILTER_EN to drop datagrams not addressed to LOCAL_PORTS.
module uiudp_rx_mp #(
  parameter int                     PORT_NUM    = 2,
  parameter logic [16*PORT_NUM-1:0] LOCAL_PORTS = {16'd8081, 16'd8080},
  parameter logic [15:0]            MAX_LEN     = 16'd1480
) (
  input  logic        I_R_udp_clk,
  input  logic        I_reset,
  input  logic        I_udp_ip_rvalid,
  input  logic [7:0]  I_udp_ip_rdata,
  output logic        O_R_udp_valid,
  output logic [7:0]  O_R_udp_data,
  output logic        O_R_udp_sof,
  output logic        O_R_udp_eof,
  output logic [15:0] O_R_udp_len,
  output logic [15:0] O_R_udp_src_port,
  output logic [15:0] O_R_udp_dest_port,
  output logic [1:0]  O_R_udp_chn,
  output logic        O_R_udp_err,
  output logic [15:0] O_R_udp_drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_DROP, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic        rvp_q;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] src_h_q, src_h_d;
  logic [15:0] dst_h_q, dst_h_d;
  logic [15:0] len_h_q, len_h_d;
  logic        valid_q, valid_d;
  logic [7:0]  data_q, data_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        err_q, err_d;
  logic [15:0] len_q, len_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [1:0]  chn_q, chn_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        drop_inc, hdr_exit;

  wire rv    = I_udp_ip_rvalid;
  wire start = rv && !rvp_q;
  wire last  = (cnt_q == 16'd7);
  wire bad   = (len_h_q < 16'd8) || (len_h_q > MAX_LEN);

  logic       hit;
  logic [1:0] hit_idx;
  logic       pass;
  logic [1:0] chn_sel;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    for (int i = PORT_NUM - 1; i >= 0; i--) begin
      if (dst_h_q == LOCAL_PORTS[16*i +: 16]) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

`ifdef UIUDP_RX_PORT_FILTER_EN
  assign pass    = hit;
  assign chn_sel = hit_idx;
`else
  logic unused_filt;
  assign unused_filt = ^{hit, hit_idx};
  assign pass        = 1'b1;
  assign chn_sel     = 2'd0;
`endif

  always_ff @(posedge I_R_udp_clk) begin
    if (I_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_HDR;
      S_HDR: begin
        if (!rv)              state_d = S_IDLE;
        else if (last) begin
          if (bad || !pass)   state_d = S_DROP;
          else if (len_h_q == 16'd8)
                              state_d = S_DONE;
          else                state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (!rv)                  state_d = S_IDLE;
        else if (cnt_q == len_q)  state_d = S_DONE;
      end
      S_DROP, S_DONE: if (!rv) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    src_h_d  = src_h_q;
    dst_h_d  = dst_h_q;
    len_h_d  = len_h_q;
    valid_d  = 1'b0;
    data_d   = 8'd0;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    err_d    = 1'b0;
    drop_inc = 1'b0;
    hdr_exit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (start) begin
          src_h_d[15:8] = I_udp_ip_rdata;
          cnt_d         = 16'd1;
        end
      end
      S_HDR: begin
        if (!rv) begin
          hdr_exit = 1'b1;
          err_d    = 1'b1;
          drop_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
          unique case (cnt_q)
            16'd1: src_h_d[7:0]  = I_udp_ip_rdata;
            16'd2: dst_h_d[15:8] = I_udp_ip_rdata;
            16'd3: dst_h_d[7:0]  = I_udp_ip_rdata;
            16'd4: len_h_d[15:8] = I_udp_ip_rdata;
            16'd5: len_h_d[7:0]  = I_udp_ip_rdata;
            default: ;
          endcase
          if (last) begin
            hdr_exit = 1'b1;
            cnt_d    = 16'd1;
            err_d    = bad;
            drop_inc = bad || !pass;
          end
        end
      end
      S_DATA: begin
        if (!rv) begin
          err_d    = 1'b1;
          drop_inc = 1'b1;
        end else begin
          valid_d = 1'b1;
          data_d  = I_udp_ip_rdata;
          sof_d   = (cnt_q == 16'd1);
          eof_d   = (cnt_q == len_q);
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: cnt_d = 16'd0;
    endcase
  end

  always_comb begin
    len_d = len_q;
    src_d = src_q;
    dst_d = dst_q;
    chn_d = chn_q;
    if (hdr_exit) begin
      len_d = len_h_q - 16'd8;
      src_d = src_h_q;
      dst_d = dst_h_q;
      chn_d = chn_sel;
    end
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge I_R_udp_clk) begin
    if (I_reset) begin
      rvp_q      <= I_udp_ip_rvalid;
      cnt_q      <= 16'd0;
      src_h_q    <= 16'd0;
      dst_h_q    <= 16'd0;
      len_h_q    <= 16'd0;
      valid_q    <= 1'b0;
      data_q     <= 8'd0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      err_q      <= 1'b0;
      len_q      <= 16'd0;
      src_q      <= 16'd0;
      dst_q      <= 16'd0;
      chn_q      <= 2'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      rvp_q      <= I_udp_ip_rvalid;
      cnt_q      <= cnt_d;
      src_h_q    <= src_h_d;
      dst_h_q    <= dst_h_d;
      len_h_q    <= len_h_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      err_q      <= err_d;
      len_q      <= len_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      chn_q      <= chn_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign O_R_udp_valid     = valid_q;
  assign O_R_udp_data      = data_q;
  assign O_R_udp_sof       = sof_q;
  assign O_R_udp_eof       = eof_q;
  assign O_R_udp_err       = err_q;
  assign O_R_udp_len       = len_q;
  assign O_R_udp_src_port  = src_q;
  assign O_R_udp_dest_port = dst_q;
  assign O_R_udp_chn       = chn_q;
  assign O_R_udp_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_uiudp_rx_mp.sv
// tb_uiudp_rx_mp: directed bench for the UDP receive parser.
// Expectations adapt to UIUDP_RX_PORT_FILTER_EN.
module tb_uiudp_rx_mp;

`ifdef UIUDP_RX_PORT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rv;
  logic [7:0]  rd;
  logic        vo, sof, eof, err;
  logic [7:0]  dout;
  logic [15:0] len, src, dst, drop;
  logic [1:0]  chn;

  always #5 clk = ~clk;

  uiudp_rx_mp dut (
    .I_R_udp_clk(clk), .I_reset(rst),
    .I_udp_ip_rvalid(rv), .I_udp_ip_rdata(rd),
    .O_R_udp_valid(vo), .O_R_udp_data(dout),
    .O_R_udp_sof(sof), .O_R_udp_eof(eof),
    .O_R_udp_len(len), .O_R_udp_src_port(src),
    .O_R_udp_dest_port(dst), .O_R_udp_chn(chn),
    .O_R_udp_err(err), .O_R_udp_drop_cnt(drop)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start = 0;
  int err_cnt = 0;
  int bad_idle = 0;
  logic [15:0] exp_drop = 16'd0;
  logic [7:0]  tx[$];
  logic [7:0]  oq_d[$];
  logic        oq_s[$], oq_e[$];
  int          oq_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vo) begin
      oq_d.push_back(dout);
      oq_s.push_back(sof);
      oq_e.push_back(eof);
      oq_c.push_back(cyc);
    end else if (dout != 8'd0 || sof || eof) begin
      bad_idle++;
    end
    if (err) err_cnt++;
  end

  task automatic clr();
    oq_d.delete(); oq_s.delete(); oq_e.delete(); oq_c.delete();
    err_cnt = 0;
  endtask

  task automatic mk_hdr(input logic [15:0] s, input logic [15:0] d,
                        input logic [15:0] l);
    tx.delete();
    tx.push_back(s[15:8]); tx.push_back(s[7:0]);
    tx.push_back(d[15:8]); tx.push_back(d[7:0]);
    tx.push_back(l[15:8]); tx.push_back(l[7:0]);
    tx.push_back(8'h00);   tx.push_back(8'h00);
  endtask

  task automatic send(input int n);
    clr();
    @(posedge clk); #1;
    start = cyc;
    for (int i = 0; i < n; i++) begin
      rv = 1'b1; rd = tx[i];
      @(posedge clk); #1;
    end
    rv = 1'b0; rd = 8'd0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic drop_model();
    if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rv = 1'b0; rd = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (vo !== 1'b0) begin fails++; $display("FAIL rst_valid got %0h exp 0", vo); end
    tests++; if ({dout, sof, eof, err} !== 11'd0) begin fails++; $display("FAIL rst_data got %0h exp 0", {dout, sof, eof, err}); end
    tests++; if ({len, src, dst, chn} !== 50'd0) begin fails++; $display("FAIL rst_hdr got %0h exp 0", {len, src, dst, chn}); end
    tests++; if (drop !== 16'd0) begin fails++; $display("FAIL rst_drop got %0h exp 0", drop); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [7:0] ex[4];
    ex = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    mk_hdr(16'h1234, 16'd8080, 16'h000C);
    for (int i = 0; i < 4; i++) tx.push_back(ex[i]);
    send(12);
    tests++; if (oq_d.size() !== 4) begin fails++; $display("FAIL basic_count got %0d exp 4", oq_d.size()); end
    if (oq_d.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        tests++; if (oq_d[i] !== ex[i]) begin fails++; $display("FAIL basic_data[%0d] got %0h exp %0h", i, oq_d[i], ex[i]); end
        tests++; if (oq_s[i] !== (i == 0)) begin fails++; $display("FAIL basic_sof[%0d] got %0b", i, oq_s[i]); end
        tests++; if (oq_e[i] !== (i == 3)) begin fails++; $display("FAIL basic_eof[%0d] got %0b", i, oq_e[i]); end
        tests++; if (oq_c[i] !== start + 9 + i) begin fails++; $display("FAIL basic_lat[%0d] got %0d exp %0d", i, oq_c[i], start + 9 + i); end
      end
    end
    tests++; if (len !== 16'd4) begin fails++; $display("FAIL basic_len got %0d exp 4", len); end
    tests++; if (src !== 16'h1234) begin fails++; $display("FAIL basic_src got %0h exp 1234", src); end
    tests++; if (dst !== 16'd8080) begin fails++; $display("FAIL basic_dst got %0d exp 8080", dst); end
    tests++; if (chn !== 2'd0) begin fails++; $display("FAIL basic_chn got %0d exp 0", chn); end
    tests++; if (err_cnt !== 0) begin fails++; $display("FAIL basic_err got %0d exp 0", err_cnt); end
  endtask

  task automatic test_single_pad();
    mk_hdr(16'h0102, 16'd8081, 16'd9);
    tx.push_back(8'h55);
    for (int i = 0; i < 17; i++) tx.push_back(8'hE0 + 8'(i));
    send(26);
    tests++; if (oq_d.size() !== 1) begin fails++; $display("FAIL pad_count got %0d exp 1", oq_d.size()); end
    if (oq_d.size() >= 1) begin
      tests++; if ({oq_d[0], oq_s[0], oq_e[0]} !== {8'h55, 2'b11}) begin fails++; $display("FAIL pad_byte got %0h/%0b%0b exp 55/11", oq_d[0], oq_s[0], oq_e[0]); end
    end
    tests++; if (chn !== (FILT ? 2'd1 : 2'd0)) begin fails++; $display("FAIL pad_chn got %0d exp %0d", chn, FILT ? 1 : 0); end
    tests++; if (len !== 16'd1) begin fails++; $display("FAIL pad_len got %0d exp 1", len); end
    tests++; if (dst !== 16'd8081) begin fails++; $display("FAIL pad_dst got %0d exp 8081", dst); end
  endtask

  task automatic test_filter();
    mk_hdr(16'h7777, 16'd9000, 16'd10);
    tx.push_back(8'h01); tx.push_back(8'h02);
    send(10);
    if (FILT) drop_model();
    tests++; if (oq_d.size() !== (FILT ? 0 : 2)) begin fails++; $display("FAIL filt_count got %0d exp %0d", oq_d.size(), FILT ? 0 : 2); end
    if (oq_d.size() == 2) begin
      tests++; if ({oq_d[0], oq_d[1]} !== 16'h0102) begin fails++; $display("FAIL filt_data got %0h%0h exp 0102", oq_d[0], oq_d[1]); end
      tests++; if (chn !== 2'd0) begin fails++; $display("FAIL filt_chn got %0d exp 0", chn); end
      tests++; if (dst !== 16'd9000) begin fails++; $display("FAIL filt_dst got %0d exp 9000", dst); end
    end
    tests++; if (err_cnt !== 0) begin fails++; $display("FAIL filt_err got %0d exp 0", err_cnt); end
    tests++; if (drop !== exp_drop) begin fails++; $display("FAIL filt_drop got %0d exp %0d", drop, exp_drop); end
  endtask

  task automatic test_bad_len();
    logic [15:0] lens[2];
    lens = '{16'h0005, 16'h05DD};
    for (int k = 0; k < 2; k++) begin
      mk_hdr(16'h1111, 16'd8080, lens[k]);
      for (int i = 0; i < 4; i++) tx.push_back(8'h90 + 8'(i));
      send(12);
      drop_model();
      tests++; if (err_cnt !== 1) begin fails++; $display("FAIL badlen%0d_err got %0d exp 1", k, err_cnt); end
      tests++; if (oq_d.size() !== 0) begin fails++; $display("FAIL badlen%0d_valid got %0d exp 0", k, oq_d.size()); end
      tests++; if (drop !== exp_drop) begin fails++; $display("FAIL badlen%0d_drop got %0d exp %0d", k, drop, exp_drop); end
    end
  endtask

  task automatic test_trunc();
    mk_hdr(16'h2222, 16'd8080, 16'h0014);
    for (int i = 0; i < 5; i++) tx.push_back(8'h30 + 8'(i));
    send(13);
    drop_model();
    tests++; if (oq_d.size() !== 5) begin fails++; $display("FAIL trunc_count got %0d exp 5", oq_d.size()); end
    for (int i = 0; i < oq_d.size(); i++) begin
      tests++; if (oq_d[i] !== 8'h30 + 8'(i) || oq_e[i] !== 1'b0) begin fails++; $display("FAIL trunc_byte[%0d] got %0h eof %0b", i, oq_d[i], oq_e[i]); end
    end
    tests++; if (err_cnt !== 1) begin fails++; $display("FAIL trunc_err got %0d exp 1", err_cnt); end
    tests++; if (drop !== exp_drop) begin fails++; $display("FAIL trunc_drop got %0d exp %0d", drop, exp_drop); end
  endtask

  task automatic test_reset_mid();
    mk_hdr(16'h4321, 16'd8080, 16'd12);
    tx.push_back(8'h11); tx.push_back(8'h22);
    tx.push_back(8'h33); tx.push_back(8'h44);
    for (int i = 0; i < 4; i++) tx.push_back(8'h00);
    clr();
    @(posedge clk); #1;
    for (int i = 0; i < tx.size(); i++) begin
      rv = 1'b1; rd = tx[i]; rst = (i == 10);
      @(posedge clk); #1;
      if (i == 10) begin
        tests++; if ({vo, dout, sof, eof, err, drop} !== 28'd0) begin fails++; $display("FAIL rmid_zero got %0h exp 0", {vo, dout, sof, eof, err, drop}); end
      end
    end
    rst = 1'b0; rv = 1'b0; rd = 8'd0;
    repeat (4) @(posedge clk);
    #1;
    exp_drop = 16'd0;
    tests++; if (oq_d.size() !== 2) begin fails++; $display("FAIL rmid_count got %0d exp 2", oq_d.size()); end
    tests++; if (err_cnt !== 0) begin fails++; $display("FAIL rmid_err got %0d exp 0", err_cnt); end
    for (int i = 0; i < oq_e.size(); i++) begin
      tests++; if (oq_e[i] !== 1'b0) begin fails++; $display("FAIL rmid_eof[%0d] got 1 exp 0", i); end
    end
    mk_hdr(16'h0BAD, 16'd8080, 16'd10);
    tx.push_back(8'h5A); tx.push_back(8'hA5);
    send(10);
    tests++; if (oq_d.size() !== 2) begin fails++; $display("FAIL rnext_count got %0d exp 2", oq_d.size()); end
    if (oq_d.size() == 2) begin
      tests++; if ({oq_d[0], oq_s[0], oq_e[0], oq_d[1], oq_s[1], oq_e[1]} !== {8'h5A, 2'b10, 8'hA5, 2'b01}) begin fails++; $display("FAIL rnext_data got %0h %0h", oq_d[0], oq_d[1]); end
    end
    tests++; if (src !== 16'h0BAD) begin fails++; $display("FAIL rnext_src got %0h exp 0bad", src); end
    tests++; if (drop !== exp_drop) begin fails++; $display("FAIL rnext_drop got %0d exp %0d", drop, exp_drop); end
  endtask

  task automatic test_saturate();
    @(posedge clk); #1;
    force dut.drop_cnt_q = 16'hFFFE;
    #1;
    release dut.drop_cnt_q;
    exp_drop = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      mk_hdr(16'h3333, 16'd8080, 16'd3);
      tx.push_back(8'h01); tx.push_back(8'h02);
      send(10);
      drop_model();
      tests++; if (drop !== exp_drop) begin fails++; $display("FAIL sat%0d_drop got %0h exp %0h", k, drop, exp_drop); end
    end
    tests++; if (bad_idle !== 0) begin fails++; $display("FAIL idle_zero got %0d exp 0", bad_idle); end
  endtask

  initial begin
    rst = 1'b1; rv = 1'b0; rd = 8'd0;
    test_reset();
    test_basic();
    test_single_pad();
    test_filter();
    test_bad_len();
    test_trunc();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uiudp_rx_mp.md
UIUDP_RX_MP -- requirements
Module: uiudp_rx_mp

Parameters
- REQ-001 The block SHALL have parameter PORT_NUM, default 2: number of local destination ports accepted, range 1..4.
- REQ-002 The block SHALL have parameter LOCAL_PORTS, default {16'd8081,16'd8080}: PORT_NUM x 16-bit packed list; entry i is at bits [16i+15:16i].
- REQ-003 The block SHALL have parameter MAX_LEN, default 16'd1480: largest accepted UDP length field, header included.

Interface
- REQ-004 The block SHALL have port I_R_udp_clk, input, 1 bit: the single clock, the same clock as the IP-layer receive data.
- REQ-005 The block SHALL have port I_reset, input, 1 bit: reset, synchronous and active-high.
- REQ-006 The block SHALL have port I_udp_ip_rvalid, input, 1 bit: UDP segment byte valid from the IP layer, high for the whole segment.
- REQ-007 The block SHALL have port I_udp_ip_rdata, input, 8 bits: UDP segment byte, header first, MSB-first fields.
- REQ-008 The block SHALL have port O_R_udp_valid, output, 1 bit: payload byte valid.
- REQ-009 The block SHALL have port O_R_udp_data, output, 8 bits: payload byte.
- REQ-010 The block SHALL have port O_R_udp_sof, output, 1 bit: high with the first payload byte.
- REQ-011 The block SHALL have port O_R_udp_eof, output, 1 bit: high with the last payload byte.
- REQ-012 The block SHALL have port O_R_udp_len, output, 16 bits: payload length (length field minus 8).
- REQ-013 The block SHALL have port O_R_udp_src_port, output, 16 bits: remote source port.
- REQ-014 The block SHALL have port O_R_udp_dest_port, output, 16 bits: matched local port.
- REQ-015 The block SHALL have port O_R_udp_chn, output, 2 bits: index of the matched LOCAL_PORTS entry.
- REQ-016 The block SHALL have port O_R_udp_err, output, 1 bit: one-cycle error pulse.
- REQ-017 The block SHALL have port O_R_udp_drop_cnt, output, 16 bits: saturating count of dropped datagrams.

Function
- REQ-018 The FSM SHALL have states IDLE, HDR, DATA, DROP and DONE; the byte counter is 16 bits.
- REQ-019 IDLE SHALL go to HDR on I_udp_ip_rvalid=1 and capture byte 0 (src port MSB).
- REQ-020 HDR SHALL capture src port (bytes 0-1), dest port (2-3) and length (4-5); it SHALL ignore checksum bytes 6-7.
- REQ-021 At byte 7, if length < 8 or length > MAX_LEN, the block SHALL go to DROP, pulse err and increment drop_cnt.
- REQ-022 At byte 7, if the port filter rejects the datagram (REQ-036), the block SHALL go to DROP and increment drop_cnt with no err pulse.
- REQ-023 At byte 7, if length = 8, the block SHALL go to DONE and emit no payload and no err.
- REQ-024 At byte 7, in all other cases, the block SHALL go to DATA.
- REQ-025 On every transition out of HDR, len, src_port, dest_port and chn SHALL load and hold stable until the next datagram's HDR exit.
- REQ-026 In DATA, each input byte SHALL appear on O_R_udp_data with valid=1 exactly one cycle later.
- REQ-027 In DATA, sof SHALL be high on payload byte 1 only, and eof SHALL be high on payload byte len only; when len=1, sof and eof SHALL be high together.
- REQ-028 After the eof byte, the block SHALL enter DONE, and trailing bytes (Ethernet padding) SHALL NOT be forwarded.
- REQ-029 DONE and DROP SHALL wait for I_udp_ip_rvalid=0, then return to IDLE.
- REQ-030 If rvalid=0 in HDR or DATA before completion (truncation), the block SHALL return to IDLE, pulse err one cycle, increment drop_cnt and suppress eof; valid SHALL deassert the next cycle.
- REQ-031 When the block is not forwarding, valid, sof, eof and data SHALL be 0.
- REQ-032 drop_cnt SHALL saturate at 16'hFFFF and never wrap.
- REQ-033 If rvalid stays high across two back-to-back datagrams, the block SHALL treat them as one, and the second SHALL be discarded as padding; the IP layer guarantees at least one idle cycle between datagrams.

Reset
- REQ-034 While I_reset=1 at a clock edge, the FSM SHALL be IDLE, the counters SHALL be 0, and all outputs SHALL be 0, including drop_cnt.
- REQ-035 Reset asserted mid-datagram SHALL abort the datagram with no eof and no err; after reset, the block SHALL resume with the next rising rvalid, and any remaining bytes of the aborted datagram SHALL be discarded until rvalid=0.

Configuration
- REQ-036 With macro UIUDP_RX_PORT_FILTER_EN defined, the block SHALL compare the dest port against LOCAL_PORTS entries 0..PORT_NUM-1; the lowest matching index SHALL drive chn, and no match SHALL cause a drop.
- REQ-037 With UIUDP_RX_PORT_FILTER_EN undefined, every well-formed datagram SHALL be forwarded, chn SHALL be 0, and dest_port SHALL be the received value.

Verification
- REQ-038 The bench SHALL cover: src 0x1234, dst 8080, len 0x000C, payload AA BB CC DD -> 4 valid bytes one cycle delayed, sof on AA, eof on DD, len=4, chn=0, src_port=0x1234.
- REQ-039 The bench SHALL cover: dst 8081, len 9, payload 55, then 17 pad bytes -> single byte with sof=eof=1, chn=1, no pad forwarded.
- REQ-040 The bench SHALL cover: dst 9000 with filter enabled -> no valid, drop_cnt +1, err=0; same datagram with filter disabled -> forwarded, chn=0.
- REQ-041 The bench SHALL cover: len field 0x0005, then 0x05DD with MAX_LEN=1480 -> err pulse each time, drop_cnt=2, no valid.
- REQ-042 The bench SHALL cover: len 0x0014 with rvalid dropped after payload byte 5 -> 5 bytes forwarded, no eof, err pulse, drop_cnt +1.
- REQ-043 The bench SHALL cover: reset asserted on payload byte 3 -> outputs 0 next cycle; the next datagram is received correctly; drop_cnt preset near 0xFFFF plus two drops -> holds 0xFFFF.
